data_select_arbiter: RTL and testbench
======================================

Name: data_select_arbiter

Overview:
- Two-source arbiter and sequencer for the 8-bit A/B stream mux.
- Grants one source at a time and drives the mux `select` line (1 = A, 0 = B).
- Accepts beats from the granted source with valid/ready flow control and presents them on a registered valid/ready output stage.
- Supports round-robin, fixed and priority modes, with burst locking so a granted source keeps the path for up to MAX_BURST beats.

Parameters:
- DATA_W, 8, width of data_a/data_b/data_out.
- MAX_BURST, 4, maximum beats accepted per grant before forced release (>=1).
- CNT_W, 3, burst counter width; must hold MAX_BURST-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_mode  input  2  00 round-robin, 01 fixed A, 10 fixed B, 11 priority A.
- data_a  input  DATA_W  source A data.
- valid_a  input  1  source A beat valid.
- ready_a  output  1  source A beat accepted this cycle when valid_a & ready_a.
- data_b  input  DATA_W  source B data.
- valid_b  input  1  source B beat valid.
- ready_b  output  1  source B beat accepted when valid_b & ready_b.
- select  output  1  mux select: 1 = A, 0 = B; registered.
- data_out  output  DATA_W  registered output data.
- valid_out  output  1  output beat valid.
- ready_in  input  1  downstream ready; beat leaves when valid_out & ready_in.
- busy  output  1  high while in GRANT_A or GRANT_B.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces state=IDLE, valid_out=0, data_out=0, select=0, busy=0, burst count=0, last_grant=B (so A wins the first round-robin tie).
  - ready_a/ready_b are 0 while in reset.
- FSM states:
  - IDLE: ready_a=ready_b=0; cfg_mode is sampled only here.
    - Mode 00: if both valid, grant the source that is not last_grant; if only one valid, grant it.
    - Mode 01: grant A iff valid_a. Mode 10: grant B iff valid_b.
    - Mode 11: A if valid_a, else B if valid_b.
    - No eligible requester: stay in IDLE.
    - On grant: next state GRANT_X, select<=X, last_grant<=X, count<=0.
    - select holds its last value while in IDLE.
  - GRANT_X:
    - ready_X = !valid_out | ready_in (combinational); the other ready is 0.
    - Accept when valid_X & ready_X: data_out<=data_X, valid_out<=1, count<=count+1.
    - Release to IDLE on either condition:
      - (a) an accept with count==MAX_BURST-1;
      - (b) valid_X==0 in any grant cycle.
    - Release takes effect the next cycle. No same-cycle re-grant, so every grant switch costs exactly one IDLE cycle.
- Output stage:
  - Latency from accept to valid_out is 1 cycle.
  - If valid_out & ready_in and no new accept, valid_out<=0 (data_out holds).
  - If valid_out & !ready_in, data_out/valid_out hold and ready_X=0 (backpressure, no loss, no duplicate).
  - An accept and an output drain in the same cycle is full throughput: one beat per cycle.
- Boundary conditions:
  - MAX_BURST=1: release after every beat.
  - Count never wraps: release happens first.
  - Changing cfg_mode during a grant has no effect until the next IDLE.
  - Source valid dropping while held by backpressure releases the grant; the pending output beat still drains normally.
  - Reset mid-burst drops the pending output beat (valid_out=0).
- Width rules:
  - data paths are DATA_W.
  - count is CNT_W, zero-extended for the compare.

Test Plan:
- Reset, then mode 00, ready_in=1, valid_a and valid_b both held high, data_a=0xA0.., data_b=0xB0.. →
  - A granted first, 4 beats, 1 IDLE cycle, then B 4 beats;
  - data_out sequence A0-A3, B0-B3;
  - select 1 then 0.
- Mode 11, both valid continuously → only A is ever granted, with one IDLE bubble after every 4 beats; ready_b never asserts.
- GRANT_A, ready_in low for 3 cycles with valid_out=1 → data_out and valid_out stable, ready_a=0, no beat lost or duplicated after ready_in returns.
- GRANT_A, valid_a drops after 2 beats while valid_b is high → IDLE next cycle, then B granted; count restarts at 0.
- Mode 10 set while in GRANT_A → A burst completes, then only B is granted.
- rst_n pulsed low mid-burst with valid_out=1 → valid_out, select, busy and ready_a all 0 immediately; after release, the first tie goes to A.

Source files
------------

// File: rtl/data_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_select_arbiter
// Description : Two-source A/B stream arbiter with burst locking, mux select
//               and a registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module data_select_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] data_a,
    input  logic              valid_a,
    output logic              ready_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              valid_b,
    output logic              ready_b,
    output logic              select,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              busy
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant_a = 2'd1;
    localparam logic [1:0] c_st_grant_b = 2'd2;

    localparam logic [1:0] c_mode_rr     = 2'b00;
    localparam logic [1:0] c_mode_fix_a  = 2'b01;
    localparam logic [1:0] c_mode_fix_b  = 2'b10;
    localparam logic [1:0] c_mode_prio_a = 2'b11;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_select;
    logic              r_last_a;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;

    logic              w_in_a;
    logic              w_in_b;
    logic              w_room;
    logic              w_valid_x;
    logic [DATA_W-1:0] w_data_x;
    logic              w_accept;
    logic              w_last;
    logic              w_pick_a;
    logic              w_pick_b;

    assign w_in_a    = (r_state == c_st_grant_a);
    assign w_in_b    = (r_state == c_st_grant_b);
    assign w_room    = !r_valid_out || ready_in;
    assign ready_a   = w_in_a && w_room;
    assign ready_b   = w_in_b && w_room;
    assign w_valid_x = w_in_a ? valid_a : valid_b;
    assign w_data_x  = w_in_a ? data_a : data_b;
    assign w_accept  = (valid_a && ready_a) || (valid_b && ready_b);
    assign w_last    = (r_count == c_last_beat);

    assign select    = r_select;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign busy      = (r_state != c_st_idle);

    always_comb begin
        w_state_nxt = r_state;
        w_pick_a    = 1'b0;
        w_pick_b    = 1'b0;
        case (r_state)
            c_st_idle: begin
                case (cfg_mode)
                    c_mode_rr: begin
                        // On a tie the source that did not hold the last grant wins
                        if (valid_a && valid_b) begin
                            w_pick_a = !r_last_a;
                            w_pick_b = r_last_a;
                        end else begin
                            w_pick_a = valid_a;
                            w_pick_b = valid_b;
                        end
                    end
                    c_mode_fix_a:  w_pick_a = valid_a;
                    c_mode_fix_b:  w_pick_b = valid_b;
                    c_mode_prio_a: begin
                        w_pick_a = valid_a;
                        w_pick_b = !valid_a && valid_b;
                    end
                    default: ;
                endcase
                if (w_pick_a) begin
                    w_state_nxt = c_st_grant_a;
                end else if (w_pick_b) begin
                    w_state_nxt = c_st_grant_b;
                end
            end
            c_st_grant_a, c_st_grant_b: begin
                if (!w_valid_x || (w_accept && w_last)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_select    <= 1'b0;
            r_last_a    <= 1'b0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_idle) begin
                if (w_pick_a || w_pick_b) begin
                    r_select <= w_pick_a;
                    r_last_a <= w_pick_a;
                    r_count  <= '0;
                end
            end else if (w_accept && !w_last) begin
                // The final beat of a burst releases instead of counting on
                r_count <= r_count + 1'b1;
            end
            if (w_accept) begin
                r_data_out  <= w_data_x;
                r_valid_out <= 1'b1;
            end else if (r_valid_out && ready_in) begin
                r_valid_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_select_arbiter
// Description : Self-checking bench for data_select_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_select_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] data_a;
    logic              valid_a;
    logic              ready_a;
    logic [DATA_W-1:0] data_b;
    logic              valid_b;
    logic              ready_b;
    logic              select;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy;

    always #5 clk = ~clk;

    data_select_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_mode (cfg_mode),
        .data_a   (data_a),
        .valid_a  (valid_a),
        .ready_a  (ready_a),
        .data_b   (data_b),
        .valid_b  (valid_b),
        .ready_b  (ready_b),
        .select   (select),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: which source owns the path (0 none, 1 A, 2 B), beats taken in
    // the current grant, and the one-deep output register.
    int              m_grant;
    int              m_beats;
    logic            m_sel;
    logic            m_last_a;
    logic            m_vout;
    logic [DATA_W-1:0] m_dout;
    int              a_seq = 0;
    int              b_seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_grant  = 0;
        m_beats  = 0;
        m_sel    = 1'b0;
        m_last_a = 1'b0;
        m_vout   = 1'b0;
        m_dout   = '0;
    endfunction

    function automatic void model_step();
        bit              room;
        bit              vx;
        logic [DATA_W-1:0] d;
        int              pick;
        room = !m_vout || ready_in;
        if (m_grant == 0) begin
            pick = 0;
            case (cfg_mode)
                2'd0: pick = (valid_a && valid_b) ? (m_last_a ? 2 : 1)
                           : valid_a ? 1 : valid_b ? 2 : 0;
                2'd1: pick = valid_a ? 1 : 0;
                2'd2: pick = valid_b ? 2 : 0;
                default: pick = valid_a ? 1 : valid_b ? 2 : 0;
            endcase
            if (m_vout && ready_in) m_vout = 1'b0;
            if (pick != 0) begin
                m_grant  = pick;
                m_sel    = (pick == 1);
                m_last_a = (pick == 1);
                m_beats  = 0;
            end
        end else begin
            vx = (m_grant == 1) ? valid_a : valid_b;
            d  = (m_grant == 1) ? data_a : data_b;
            if (vx && room) begin
                m_dout = d;
                m_vout = 1'b1;
                m_beats++;
                if (m_grant == 1) a_seq++;
                else b_seq++;
            end else if (m_vout && ready_in) begin
                m_vout = 1'b0;
            end
            if (!vx || m_beats == MAX_BURST) m_grant = 0;
        end
    endfunction

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("ready_a",   ready_a,   rst_n && m_grant == 1 && (!m_vout || ready_in));
            chk("ready_b",   ready_b,   rst_n && m_grant == 2 && (!m_vout || ready_in));
            chk("select",    select,    m_sel);
            chk("busy",      busy,      m_grant != 0);
            chk("valid_out", valid_out, m_vout);
            chk("data_out",  data_out,  m_dout);
        end
    end

    bit          exp_busy [12] = '{0,1,1,1,1,0,1,1,1,1,0,1};
    bit          exp_sel  [12] = '{0,1,1,1,1,1,0,0,0,0,0,1};
    bit          exp_vout [12] = '{0,0,1,1,1,1,0,1,1,1,1,0};
    logic [7:0]  exp_drain [8] = '{8'hA0,8'hA1,8'hA2,8'hA3,8'hB0,8'hB1,8'hB2,8'hB3};
    logic [7:0]  drained [$];

    initial begin
        int n_rb;
        int pa, pb, pr;
        bit found;
        model_reset();
        cfg_mode = 2'd0; valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0; ready_in = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk); #3;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out",  data_out,  0);
        chk("rst_select",    select,    0);
        chk("rst_busy",      busy,      0);
        chk("rst_ready_a",   ready_a,   0);
        chk("rst_ready_b",   ready_b,   0);
        chk_en = 1'b1;

        // Round-robin with both sources streaming and no backpressure
        @(negedge clk);
        rst_n = 1'b1; cfg_mode = 2'd0; valid_a = 1'b1; valid_b = 1'b1; ready_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            data_a = 8'hA0 + 8'(a_seq);
            data_b = 8'hB0 + 8'(b_seq);
            #3;
            chk("p1_busy",      busy,      exp_busy[k]);
            chk("p1_select",    select,    exp_sel[k]);
            chk("p1_valid_out", valid_out, exp_vout[k]);
            if (valid_out && ready_in) drained.push_back(data_out);
        end
        chk("p1_drain_count", drained.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("p1_drain_data", (i < drained.size()) ? drained[i] : 8'hxx, exp_drain[i]);
        end

        // Priority A: B must never be granted
        n_rb = 0;
        cfg_mode = 2'd3;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            data_a = 8'($urandom); data_b = 8'($urandom);
            #3;
            if (ready_b) n_rb++;
        end
        chk("p2_ready_b_never", n_rb, 0);

        // Reset in the middle of a burst with a pending output beat
        cfg_mode = 2'd0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk); #3;
            if (busy && valid_out) found = 1'b1;
        end
        chk("p3_wait_burst", found, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        chk("p3_valid_out", valid_out, 0);
        chk("p3_select",    select,    0);
        chk("p3_busy",      busy,      0);
        chk("p3_ready_a",   ready_a,   0);
        @(negedge clk);
        rst_n = 1'b1; valid_a = 1'b1; valid_b = 1'b1;
        @(negedge clk); #3;
        chk("p3_first_tie_a", select, 1);
        chk("p3_busy_after",  busy,   1);

        // Randomized traffic with mode changes, backpressure and resets
        pa = 80; pb = 80; pr = 80;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 60 == 0) begin
                cfg_mode = 2'($urandom_range(0, 3));
                pa = $urandom_range(30, 100);
                pb = $urandom_range(30, 100);
                pr = $urandom_range(20, 100);
            end
            if ($urandom_range(0, 99) < 3) cfg_mode = 2'($urandom_range(0, 3));
            valid_a  = ($urandom_range(0, 99) < pa);
            valid_b  = ($urandom_range(0, 99) < pb);
            ready_in = ($urandom_range(0, 99) < pr);
            data_a   = 8'($urandom);
            data_b   = 8'($urandom);
            rst_n    = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #4;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
